// File: rtl/seg_score_display.sv
// BCD score counter driven by edge-detected add/sub requests, with a
// multiplexed 7-segment scan display and optional leading-zero blanking.
module seg_score_display #(
  parameter int NUM_DIGITS  = 4,
  parameter int SCAN_CYCLES = 50000,
  parameter int ACTIVE_LOW  = 1,
  parameter int BLANK_LZ    = 1
) (
  input  logic                    CLK_50M,
  input  logic                    RST,
  input  logic                    add_cube,
  input  logic                    sub_cube,
  input  logic                    clr,
  output logic [4*NUM_DIGITS-1:0] point,
  output logic                    overflow,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   sel
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(SCAN_CYCLES);
  localparam logic [7:0]            SEG_OFF = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] SEL_OFF = (ACTIVE_LOW != 0) ? '1 : '0;

  logic                    add_q, sub_q, armed;
  logic                    add_edge, sub_edge;
  logic [4*NUM_DIGITS-1:0] point_inc, point_dec;
  logic                    inc_carry, dec_borrow;
  logic [CNT_W-1:0]        scan_cnt;
  logic [IDX_W-1:0]        digit_idx;
  logic [3:0]              cur_digit;
  logic                    cur_blank;
  logic [NUM_DIGITS-1:0]   sel_n;
  logic [7:0]              seg_n;

  // armed stays low for the first cycle after reset so an input already
  // high at release loads the edge register without counting.
  assign add_edge = armed & add_cube & ~add_q;
  assign sub_edge = armed & sub_cube & ~sub_q;

  function automatic logic [7:0] seg_lut(input logic [3:0] d);
    case (d)
      4'd0:    seg_lut = 8'hC0;
      4'd1:    seg_lut = 8'hF9;
      4'd2:    seg_lut = 8'hA4;
      4'd3:    seg_lut = 8'hB0;
      4'd4:    seg_lut = 8'h99;
      4'd5:    seg_lut = 8'h92;
      4'd6:    seg_lut = 8'h82;
      4'd7:    seg_lut = 8'hF8;
      4'd8:    seg_lut = 8'h80;
      4'd9:    seg_lut = 8'h90;
      default: seg_lut = 8'hFF;
    endcase
  endfunction

  always_comb begin
    point_inc = point;
    inc_carry = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (inc_carry) begin
        if (point[4*i +: 4] == 4'd9) begin
          point_inc[4*i +: 4] = 4'd0;
        end else begin
          point_inc[4*i +: 4] = point[4*i +: 4] + 4'd1;
          inc_carry = 1'b0;
        end
      end
    end
  end

  always_comb begin
    point_dec  = point;
    dec_borrow = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (dec_borrow) begin
        if (point[4*i +: 4] == 4'd0) begin
          point_dec[4*i +: 4] = 4'd9;
        end else begin
          point_dec[4*i +: 4] = point[4*i +: 4] - 4'd1;
          dec_borrow = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      point    <= '0;
      overflow <= 1'b0;
      add_q    <= 1'b0;
      sub_q    <= 1'b0;
      armed    <= 1'b0;
    end else begin
      armed <= 1'b1;
      add_q <= add_cube;
      sub_q <= sub_cube;
      if (clr) begin
        point    <= '0;
        overflow <= 1'b0;
      end else if (add_edge && sub_edge) begin
        point <= point;
      end else if (add_edge) begin
        if (inc_carry) overflow <= 1'b1;
        else           point    <= point_inc;
      end else if (sub_edge) begin
        if (!dec_borrow) point <= point_dec;
      end
    end
  end

  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
    end else if (scan_cnt == CNT_W'(SCAN_CYCLES - 1)) begin
      scan_cnt  <= '0;
      digit_idx <= (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + IDX_W'(1);
    end else begin
      scan_cnt <= scan_cnt + CNT_W'(1);
    end
  end

  // A digit is a leading zero when it and every digit above it are zero,
  // i.e. the score shifted down to that digit is zero.
  always_comb begin
    cur_digit = '0;
    cur_blank = 1'b0;
    sel_n     = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (digit_idx == IDX_W'(i)) begin
        sel_n[i]  = 1'b1;
        cur_digit = point[4*i +: 4];
        cur_blank = (BLANK_LZ != 0) && (i != 0) && ((point >> (4*i)) == '0);
      end
    end
    seg_n = cur_blank ? 8'hFF : seg_lut(cur_digit);
  end

  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      sel     <= SEL_OFF;
      seg_out <= SEG_OFF;
    end else begin
      sel     <= (ACTIVE_LOW != 0) ? ~sel_n : sel_n;
      seg_out <= (ACTIVE_LOW != 0) ? seg_n : ~seg_n;
    end
  end

endmodule

// File: tb/tb_seg_score_display.sv
// Directed bench for seg_score_display: a 4-digit active-low instance with a
// short scan period and a 2-digit active-high instance share all inputs.
module tb_seg_score_display;

  logic        CLK_50M;
  logic        RST;
  logic        add_cube;
  logic        sub_cube;
  logic        clr;
  logic [15:0] point;
  logic        overflow;
  logic [7:0]  seg_out;
  logic [3:0]  sel;
  logic [7:0]  point2;
  logic        overflow2;
  logic [7:0]  seg_out2;
  logic [1:0]  sel2;

  int unsigned tests_run;
  int unsigned tests_failed;

  seg_score_display #(.NUM_DIGITS(4), .SCAN_CYCLES(8)) dut (
    .CLK_50M (CLK_50M),
    .RST     (RST),
    .add_cube(add_cube),
    .sub_cube(sub_cube),
    .clr     (clr),
    .point   (point),
    .overflow(overflow),
    .seg_out (seg_out),
    .sel     (sel)
  );

  seg_score_display #(.NUM_DIGITS(2), .SCAN_CYCLES(4), .ACTIVE_LOW(0)) dut2 (
    .CLK_50M (CLK_50M),
    .RST     (RST),
    .add_cube(add_cube),
    .sub_cube(sub_cube),
    .clr     (clr),
    .point   (point2),
    .overflow(overflow2),
    .seg_out (seg_out2),
    .sel     (sel2)
  );

  initial CLK_50M = 1'b0;
  always #5 CLK_50M = ~CLK_50M;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_50M);
    #1;
  endtask

  task automatic pulse(input logic a, input logic s);
    add_cube = a;
    sub_cube = s;
    tick();
    add_cube = 1'b0;
    sub_cube = 1'b0;
    tick();
  endtask

  task automatic wait_sel(input logic [3:0] want);
    for (int n = 0; n < 64 && sel !== want; n++) tick();
  endtask

  task automatic wait_sel2(input logic [1:0] want);
    for (int n = 0; n < 64 && sel2 !== want; n++) tick();
  endtask

  initial begin
    logic [3:0] exp_sel;
    logic [7:0] exp_seg;
    int unsigned d;
    tests_run    = 0;
    tests_failed = 0;
    RST      = 1'b1;
    add_cube = 1'b0;
    sub_cube = 1'b0;
    clr      = 1'b0;
    repeat (3) tick();
    check_val("rst_point",  point,    32'h0);
    check_val("rst_ovf",    overflow, 32'h0);
    check_val("rst_sel",    sel,      32'hF);
    check_val("rst_seg",    seg_out,  32'hFF);
    check_val("rst_sel2",   sel2,     32'h0);
    check_val("rst_seg2",   seg_out2, 32'h00);

    // Idle scan after release: each digit slot lasts 8 (dut) / 4 (dut2) cycles.
    RST = 1'b0;
    for (int unsigned k = 1; k <= 33; k++) begin
      tick();
      d       = ((k - 1) / 8) % 4;
      exp_sel = ~(4'b0001 << d);
      exp_seg = (d == 0) ? 8'hC0 : 8'hFF;
      check_val($sformatf("idle_sel_%0d", k), sel, exp_sel);
      check_val($sformatf("idle_seg_%0d", k), seg_out, exp_seg);
      d = ((k - 1) / 4) % 2;
      check_val($sformatf("idle_sel2_%0d", k), sel2, (d == 0) ? 32'h1 : 32'h2);
      check_val($sformatf("idle_seg2_%0d", k), seg_out2, (d == 0) ? 32'h3F : 32'h00);
    end

    repeat (7) pulse(1'b1, 1'b0);
    check_val("pt_0007",  point,  32'h0007);
    check_val("pt2_07",   point2, 32'h07);
    wait_sel2(2'b01);
    check_val("d2_sel_lo", sel2,     32'h1);
    check_val("d2_seg_lo", seg_out2, 32'h07);
    wait_sel2(2'b10);
    check_val("d2_sel_hi", sel2,     32'h2);
    check_val("d2_seg_hi", seg_out2, 32'h00);

    repeat (92) pulse(1'b1, 1'b0);
    check_val("pt_0099",  point,     32'h0099);
    check_val("pt2_99",   point2,    32'h99);
    check_val("ovf2_pre", overflow2, 32'h0);
    pulse(1'b1, 1'b0);
    check_val("pt_0100",  point,     32'h0100);
    check_val("ovf_0100", overflow,  32'h0);
    check_val("pt2_sat",  point2,    32'h99);
    check_val("ovf2_set", overflow2, 32'h1);

    wait_sel(4'b1011);
    check_val("sel_d2", sel, 32'hB);
    check_val("seg_d2", seg_out, 32'hF9);
    wait_sel(4'b0111);
    check_val("sel_d3", sel, 32'h7);
    check_val("seg_d3", seg_out, 32'hFF);
    wait_sel(4'b1110);
    check_val("sel_d0", sel, 32'hE);
    check_val("seg_d0", seg_out, 32'hC0);
    wait_sel(4'b1101);
    check_val("sel_d1", sel, 32'hD);
    check_val("seg_d1", seg_out, 32'hC0);

    pulse(1'b0, 1'b1);
    check_val("sub_0099",  point,     32'h0099);
    check_val("sub2_98",   point2,    32'h98);
    check_val("ovf2_hold", overflow2, 32'h1);

    add_cube = 1'b1;
    repeat (1000) tick();
    add_cube = 1'b0;
    tick();
    check_val("hold_once", point, 32'h0100);

    pulse(1'b1, 1'b1);
    check_val("both_nochg", point, 32'h0100);

    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    check_val("clr_point", point,     32'h0);
    check_val("clr_ovf2",  overflow2, 32'h0);
    check_val("clr_pt2",   point2,    32'h0);

    pulse(1'b0, 1'b1);
    check_val("sub_zero",     point,    32'h0);
    check_val("sub_zero_ovf", overflow, 32'h0);

    repeat (9999) pulse(1'b1, 1'b0);
    check_val("pt_9999",  point,    32'h9999);
    check_val("ovf_9999", overflow, 32'h0);
    pulse(1'b1, 1'b0);
    check_val("sat_9999", point,    32'h9999);
    check_val("ovf_set",  overflow, 32'h1);
    pulse(1'b0, 1'b1);
    check_val("sub_9998", point,    32'h9998);
    check_val("ovf_stky", overflow, 32'h1);

    clr      = 1'b1;
    add_cube = 1'b1;
    tick();
    check_val("clr_pt",  point,    32'h0);
    check_val("clr_ovf", overflow, 32'h0);
    add_cube = 1'b0;
    clr      = 1'b0;
    repeat (2) tick();
    check_val("clr_discard", point, 32'h0);

    repeat (3) pulse(1'b1, 1'b0);
    check_val("pt_0003", point, 32'h0003);
    add_cube = 1'b1;
    RST      = 1'b1;
    tick();
    check_val("midrst_pt",  point, 32'h0);
    check_val("midrst_sel", sel,   32'hF);
    RST = 1'b0;
    tick();
    check_val("rel_sel", sel,     32'hE);
    check_val("rel_seg", seg_out, 32'hC0);
    repeat (2) tick();
    check_val("rel_held", point, 32'h0);
    add_cube = 1'b0;
    tick();
    pulse(1'b1, 1'b0);
    check_val("rel_arm", point, 32'h0001);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
